// File: rtl/fs_backing_store.sv
// Responder end of the fs* page-swap interface: word data store plus 4-bit page
// metadata store, power-up metadata scrub, sticky protocol-fault latch and swap counter.
module fs_backing_store #(
    parameter int          width        = 32,
    parameter int          storewidthad = 16,
    parameter int          metawidthad  = 10,
    parameter logic [3:0]  META_DEFAULT = 4'b0110
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fsAccess,
    input  logic             fsRden,
    input  logic             fsWren,
    input  logic             fsMeta,
    input  logic [31:0]      fsAddress,
    input  logic [width-1:0] fsData,
    output logic [width-1:0] fsQ,
    output logic             busy,
    output logic             fault,
    output logic [1:0]       fault_code,
    input  logic             clear_fault,
    output logic [15:0]      swap_count
);

    typedef enum logic {ST_SCRUB, ST_SERVE} state_t;
    typedef enum logic [1:0] {SRC_ZERO, SRC_DATA, SRC_META} src_t;

    localparam logic [1:0] FAULT_NONE    = 2'd0;
    localparam logic [1:0] FAULT_RANGE   = 2'd1;
    localparam logic [1:0] FAULT_COLLIDE = 2'd2;
    localparam logic [1:0] FAULT_BUSY    = 2'd3;

    localparam logic [metawidthad-1:0] SCRUB_LAST = '1;

    state_t                 state_q, state_d;
    logic [metawidthad-1:0] scrub_idx_q, scrub_idx_d;
    src_t                   src_q, src_d;
    logic [1:0]             fault_code_q, fault_code_d;
    logic [1:0]             new_fault;
    logic                   access_prev_q;
    logic [15:0]            swap_count_q;

    logic [width-1:0]       data_mem [2**storewidthad];
    logic [3:0]             meta_mem [2**metawidthad];
    logic [width-1:0]       data_rdata_q;
    logic [3:0]             meta_rdata_q;

    logic                   data_we, data_re, meta_we, meta_re;
    logic [metawidthad-1:0] meta_addr;
    logic [3:0]             meta_wdata;
    logic                   data_oor, meta_oor, addr_oor;

    // Upper address bits are checked rather than dropped so aliasing never happens.
    assign data_oor = (fsAddress >> storewidthad) != '0;
    assign meta_oor = (fsAddress >> metawidthad) != '0;
    assign addr_oor = fsMeta ? meta_oor : data_oor;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        scrub_idx_d = scrub_idx_q;
        src_d       = src_q;
        new_fault   = FAULT_NONE;
        data_we     = 1'b0;
        data_re     = 1'b0;
        meta_we     = 1'b0;
        meta_re     = 1'b0;
        meta_addr   = fsAddress[metawidthad-1:0];
        meta_wdata  = fsData[3:0];
        unique case (state_q)
            ST_SCRUB: begin
                meta_we     = 1'b1;
                meta_addr   = scrub_idx_q;
                meta_wdata  = META_DEFAULT;
                scrub_idx_d = scrub_idx_q + 1'b1;
                if (scrub_idx_q == SCRUB_LAST) state_d = ST_SERVE;
                if (fsRden || fsWren) new_fault = FAULT_BUSY;
            end
            ST_SERVE: begin
                if (fsWren && !addr_oor) begin
                    data_we = !fsMeta;
                    meta_we = fsMeta;
                end
                if (fsRden) begin
                    if (fsWren || addr_oor) begin
                        src_d = SRC_ZERO;
                    end else begin
                        data_re = !fsMeta;
                        meta_re = fsMeta;
                        src_d   = fsMeta ? SRC_META : SRC_DATA;
                    end
                end
                if (fsRden && fsWren)                  new_fault = FAULT_COLLIDE;
                else if ((fsRden || fsWren) && addr_oor) new_fault = FAULT_RANGE;
            end
            default: ;
        endcase
        // Nothing touches the stores while reset is held.
        if (rst) begin
            data_we = 1'b0;
            data_re = 1'b0;
            meta_we = 1'b0;
            meta_re = 1'b0;
        end
    end

    // A clear on the same edge as a new fault keeps the new fault.
    always_comb begin
        fault_code_d = fault_code_q;
        if (clear_fault)                     fault_code_d = new_fault;
        else if (fault_code_q == FAULT_NONE) fault_code_d = new_fault;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SCRUB;
            scrub_idx_q   <= '0;
            src_q         <= SRC_ZERO;
            fault_code_q  <= FAULT_NONE;
            access_prev_q <= 1'b0;
            swap_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            scrub_idx_q   <= scrub_idx_d;
            src_q         <= src_d;
            fault_code_q  <= fault_code_d;
            access_prev_q <= fsAccess;
            if (fsAccess && !access_prev_q) swap_count_q <= swap_count_q + 16'd1;
        end
    end

    // NOTE: store arrays and their read registers carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[fsAddress[storewidthad-1:0]] <= fsData;
        if (data_re) data_rdata_q <= data_mem[fsAddress[storewidthad-1:0]];
    end

    always_ff @(posedge clk) begin
        if (meta_we) meta_mem[meta_addr] <= meta_wdata;
        if (meta_re) meta_rdata_q <= meta_mem[meta_addr];
    end

    // src_q remembers which read register fsQ shows, so fsQ holds between reads.
    always_comb begin
        fsQ = '0;
        unique case (src_q)
            SRC_DATA: fsQ = data_rdata_q;
            SRC_META: fsQ = width'(meta_rdata_q);
            default:  ;
        endcase
    end

    assign busy       = (state_q == ST_SCRUB);
    assign fault_code = fault_code_q;
    assign fault      = |fault_code_q;
    assign swap_count = swap_count_q;

endmodule

// File: tb/tb_fs_backing_store.sv
// Self-checking bench for fs_backing_store: directed scenarios plus randomized
// traffic compared against a behavioural model of the stores and fault latch.
module tb_fs_backing_store;

    localparam int W   = 32;
    localparam int SAW = 16;
    localparam int MAW = 4;

    logic          clk = 1'b0;
    logic          rst, fsAccess, fsRden, fsWren, fsMeta, clear_fault;
    logic [31:0]   fsAddress;
    logic [W-1:0]  fsData, fsQ;
    logic          busy, fault;
    logic [1:0]    fault_code;
    logic [15:0]   swap_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Behavioural model state
    int            scrub_left;
    logic [31:0]   m_q;
    logic [1:0]    m_code;
    int            m_count;
    logic          m_prev;
    logic [3:0]    m_meta [16];
    logic [31:0]   m_data [int unsigned];

    fs_backing_store #(.width(W), .storewidthad(SAW), .metawidthad(MAW), .META_DEFAULT(4'b0110)) dut (
        .clk(clk), .rst(rst), .fsAccess(fsAccess), .fsRden(fsRden), .fsWren(fsWren),
        .fsMeta(fsMeta), .fsAddress(fsAddress), .fsData(fsData), .fsQ(fsQ),
        .busy(busy), .fault(fault), .fault_code(fault_code), .clear_fault(clear_fault),
        .swap_count(swap_count)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        int unsigned a;
        logic [1:0]  nf;
        logic        oor;
        a  = fsAddress;
        nf = 2'd0;
        if (rst) begin
            scrub_left = 16; m_q = '0; m_code = 2'd0; m_count = 0; m_prev = 1'b0;
            return;
        end
        if (fsAccess && !m_prev) m_count = (m_count + 1) % 65536;
        m_prev = fsAccess;
        if (scrub_left > 0) begin
            if (fsRden || fsWren) nf = 2'd3;
            scrub_left--;
            if (scrub_left == 0) foreach (m_meta[i]) m_meta[i] = 4'h6;
        end else begin
            oor = fsMeta ? (a >= 16) : (a >= 65536);
            if (fsWren && !oor) begin
                if (fsMeta) m_meta[a] = fsData[3:0];
                else        m_data[a] = fsData;
            end
            if (fsRden && fsWren) begin
                nf = 2'd2; m_q = '0;
            end else if (fsWren) begin
                if (oor) nf = 2'd1;
            end else if (fsRden) begin
                if (oor) begin nf = 2'd1; m_q = '0; end
                else m_q = fsMeta ? {28'b0, m_meta[a]} : m_data[a];
            end
        end
        if (clear_fault)         m_code = nf;
        else if (m_code == 2'd0) m_code = nf;
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic meta,
                         input logic [31:0] addr, input logic [31:0] data);
        fsRden = rd; fsWren = wr; fsMeta = meta; fsAddress = addr; fsData = data;
        clear_fault = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 40 && busy; i++) begin
            n++;
            tick();
        end
        total_cnt++;
        if (n !== 16) $display("FAIL %s busy_cycles got %0d want 16", name, n); else pass_cnt++;
    endtask

    task automatic test_reset();
        idle(); fsAccess = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        total_cnt++;
        if ({fsQ, fault, fault_code, swap_count, busy} !== {32'd0, 1'b0, 2'd0, 16'd0, 1'b1})
            $display("FAIL reset_state fsQ=%h fault=%b code=%0d swaps=%0d busy=%b want 0/0/0/0/1",
                     fsQ, fault, fault_code, swap_count, busy);
        else pass_cnt++;
        count_busy("scrub_len");
        total_cnt++;
        if (fault_code !== 2'd0) $display("FAIL scrub_no_fault got %0d want 0", fault_code); else pass_cnt++;
    endtask

    task automatic test_meta_default();
        drive(1'b1, 1'b0, 1'b1, 32'd5, 32'd0);
        tick(); idle();
        total_cnt++;
        if (fsQ !== 32'h6) $display("FAIL meta_default got %h want 00000006", fsQ); else pass_cnt++;
    endtask

    task automatic test_write_read();
        drive(1'b0, 1'b1, 1'b0, 32'h1234, 32'hDEADBEEF);
        tick();
        total_cnt++;
        if (fsQ !== 32'h6) $display("FAIL write_holds_q got %h want 00000006", fsQ); else pass_cnt++;
        drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'd0);
        tick(); idle();
        total_cnt++;
        if (fsQ !== 32'hDEADBEEF) $display("FAIL write_read got %h want deadbeef", fsQ); else pass_cnt++;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'(i), 32'(i * 3));
            tick();
        end
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'(i), 32'd0);
            tick();
            total_cnt++;
            if (fsQ !== 32'(i * 3)) $display("FAIL stream[%0d] got %0d want %0d", i, fsQ, i * 3);
            else pass_cnt++;
        end
        idle(); tick();
        total_cnt++;
        if (fsQ !== 32'd189) $display("FAIL stream_hold got %0d want 189", fsQ); else pass_cnt++;
    endtask

    task automatic test_out_of_range();
        drive(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'd0);
        tick();
        total_cnt++;
        if ({fsQ, fault, fault_code} !== {32'd0, 1'b1, 2'd1})
            $display("FAIL oor_read fsQ=%h fault=%b code=%0d want 0/1/1", fsQ, fault, fault_code);
        else pass_cnt++;
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h60);
        tick();
        total_cnt++;
        if (fault_code !== 2'd1) $display("FAIL first_fault_kept got %0d want 1", fault_code); else pass_cnt++;
        drive(1'b0, 1'b1, 1'b0, 32'h0001_1234, 32'h0BAD_0BAD);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'd16, 32'hF);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'd0);
        tick();
        total_cnt++;
        if (fsQ !== 32'hDEADBEEF) $display("FAIL oor_write_dropped got %h want deadbeef", fsQ); else pass_cnt++;
        drive(1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
        tick(); idle();
        total_cnt++;
        if (fsQ !== 32'h6) $display("FAIL meta_oor_no_wrap got %h want 00000006", fsQ); else pass_cnt++;
    endtask

    task automatic test_collision();
        idle(); clear_fault = 1'b1;
        tick(); clear_fault = 1'b0;
        total_cnt++;
        if ({fault, fault_code} !== 3'b0_00) $display("FAIL clear_fault got %b/%0d want 0/0", fault, fault_code);
        else pass_cnt++;
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'd7);
        tick(); idle();
        total_cnt++;
        if ({fsQ, fault_code} !== {32'd0, 2'd2}) $display("FAIL collision fsQ=%h code=%0d want 0/2", fsQ, fault_code);
        else pass_cnt++;
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h10, 32'd0);
        tick(); idle();
        total_cnt++;
        if (fsQ !== 32'd7) $display("FAIL collision_write got %0d want 7", fsQ); else pass_cnt++;
        drive(1'b1, 1'b0, 1'b1, 32'd99, 32'd0); clear_fault = 1'b1;
        tick(); idle();
        total_cnt++;
        if (fault_code !== 2'd1) $display("FAIL clear_vs_new got %0d want 1", fault_code); else pass_cnt++;
        clear_fault = 1'b1; tick(); clear_fault = 1'b0;
    endtask

    task automatic test_swap_count();
        logic [15:0] start;
        start = swap_count;
        for (int i = 0; i < 5; i++) begin
            fsAccess = 1'b1; tick(); tick();
            fsAccess = 1'b0; tick();
        end
        fsAccess = 1'b1; repeat (4) tick();
        fsAccess = 1'b0; tick();
        total_cnt++;
        if (swap_count !== start + 16'd6) $display("FAIL swap_count got %0d want %0d", swap_count, start + 16'd6);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic meta, oor;
        logic [31:0] addr;
        for (int n = 0; n < 300; n++) begin
            meta = 1'($urandom_range(0, 1));
            oor  = ($urandom_range(0, 9) == 0);
            if (meta) addr = oor ? 32'(16 + $urandom_range(0, 100)) : 32'($urandom_range(0, 15));
            else      addr = oor ? 32'(65536 + $urandom_range(0, 1000)) : 32'($urandom_range(0, 63));
            drive(1'($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0), meta, addr, $urandom);
            clear_fault = ($urandom_range(0, 7) == 0);
            fsAccess    = 1'($urandom_range(0, 1));
            tick();
            total_cnt++;
            if (fsQ !== m_q) $display("FAIL rand_q[%0d] got %h want %h", n, fsQ, m_q); else pass_cnt++;
            total_cnt++;
            if ({fault, fault_code} !== {|m_code, m_code})
                $display("FAIL rand_fault[%0d] got %b/%0d want %b/%0d", n, fault, fault_code, |m_code, m_code);
            else pass_cnt++;
            total_cnt++;
            if (swap_count !== 16'(m_count)) $display("FAIL rand_swaps[%0d] got %0d want %0d", n, swap_count, m_count);
            else pass_cnt++;
        end
        idle(); fsAccess = 1'b0; clear_fault = 1'b1; tick(); clear_fault = 1'b0;
    endtask

    task automatic test_busy_fault();
        idle(); rst = 1'b1; tick(); rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'd0);
        tick();
        total_cnt++;
        if ({fsQ, busy, fault_code} !== {32'd0, 1'b1, 2'd3})
            $display("FAIL busy_strobe fsQ=%h busy=%b code=%0d want 0/1/3", fsQ, busy, fault_code);
        else pass_cnt++;
        drive(1'b0, 1'b1, 1'b0, 32'h1234, 32'h55);
        tick(); idle();
        repeat (3) tick();
        rst = 1'b1; tick(); rst = 1'b0;
        total_cnt++;
        if ({fault, busy} !== 2'b01) $display("FAIL mid_scrub_reset fault=%b busy=%b want 0/1", fault, busy);
        else pass_cnt++;
        count_busy("rescrub_len");
        drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'd0);
        tick(); idle();
        total_cnt++;
        if (fsQ !== 32'hDEADBEEF) $display("FAIL data_survives_reset got %h want deadbeef", fsQ); else pass_cnt++;
        total_cnt++;
        if (busy !== (scrub_left > 0)) $display("FAIL model_busy got %b want %b", busy, scrub_left > 0);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; fsAccess = 1'b0; idle();
        scrub_left = 16; m_q = '0; m_code = 2'd0; m_count = 0; m_prev = 1'b0;
        foreach (m_meta[i]) m_meta[i] = 4'h6;
        test_reset();
        test_meta_default();
        test_write_read();
        test_stream();
        test_out_of_range();
        test_collision();
        test_swap_count();
        test_random();
        test_busy_fault();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
